// File: rtl/stream_demultiplexer.sv
// 1-to-4 valid/ready routing demultiplexer: in_sel steers each input word into
// one of four single-entry registered channel buffers (a/b/c/d).
module stream_demultiplexer #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [WIDTH-1:0]     out_data_a,
  output logic [WIDTH-1:0]     out_data_b,
  output logic [WIDTH-1:0]     out_data_c,
  output logic [WIDTH-1:0]     out_data_d,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  logic [WIDTH-1:0] buf_q [4];
  logic [3:0]       load;
  logic [3:0]       drain;
  logic             accept;

  // NOTE: combinational logic uses blocking assignments with every output
  // given a default first, so no latch can be inferred.
  always_comb begin
    load     = 4'b0000;
    in_ready = !out_valid[in_sel] || out_ready[in_sel];
    accept   = in_valid && in_ready;
    drain    = out_valid & out_ready;
    if (accept) load[in_sel] = 1'b1;
  end

  for (genvar k = 0; k < 4; k++) begin : g_chan
    // A load wins over a same-edge drain so a draining channel refills at full rate.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid[k] <= 1'b0;
      end else if (load[k]) begin
        out_valid[k] <= 1'b1;
      end else if (drain[k]) begin
        out_valid[k] <= 1'b0;
      end
    end

    // NOTE: the data buffers are reset too, because zeroed outputs after reset
    // are part of the visible behaviour, not just a nicety.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        buf_q[k] <= '0;
      end else if (load[k]) begin
        buf_q[k] <= in_data;
      end
    end
  end

  // Free-running modulo counter of accepted words; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (accept) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end

  assign out_data_a = buf_q[0];
  assign out_data_b = buf_q[1];
  assign out_data_c = buf_q[2];
  assign out_data_d = buf_q[3];

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Scoreboard bench for stream_demultiplexer: a queue-per-channel reference model
// predicts accepts and routed words; a negedge monitor checks every output.
module tb_stream_demultiplexer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   in_sel = 2'd0;
  logic [W-1:0] in_data = '0;
  logic [3:0]   out_ready = 4'b0000;

  logic         in_ready, in_ready_s;
  logic [3:0]   out_valid, out_valid_s;
  logic [W-1:0] out_data_a, out_data_b, out_data_c, out_data_d;
  logic [W-1:0] out_data_a_s, out_data_b_s, out_data_c_s, out_data_d_s;
  logic [15:0]  xfer_count;
  logic [3:0]   xfer_count_s;

  always #5 clk = ~clk;

  stream_demultiplexer #(.WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data_a(out_data_a), .out_data_b(out_data_b), .out_data_c(out_data_c),
    .out_data_d(out_data_d), .xfer_count(xfer_count)
  );

  // Narrow-counter instance sharing the same stimulus, used for the wrap check.
  stream_demultiplexer #(.WIDTH(W), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data_a(out_data_a_s), .out_data_b(out_data_b_s), .out_data_c(out_data_c_s),
    .out_data_d(out_data_d_s), .xfer_count(xfer_count_s)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: each channel is a queue holding at most one word.
  logic [W-1:0] q [4][$];
  int           n_acc = 0;
  logic         mon_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] dat(input int k);
    case (k)
      0:       return out_data_a;
      1:       return out_data_b;
      2:       return out_data_c;
      default: return out_data_d;
    endcase
  endfunction

  function automatic logic [W-1:0] dat_s(input int k);
    case (k)
      0:       return out_data_a_s;
      1:       return out_data_b_s;
      2:       return out_data_c_s;
      default: return out_data_d_s;
    endcase
  endfunction

  // Predictor: a word is taken whenever its channel has room after this edge's drain.
  always @(posedge clk) begin
    if (rst_n && in_valid && q[int'(in_sel)].size() == 0) begin
      q[int'(in_sel)].push_back(in_data);
      n_acc++;
    end
  end

  always @(negedge rst_n) begin
    for (int k = 0; k < 4; k++) q[k].delete();
    n_acc = 0;
  end

  // Monitor: compare outputs with the model, retire words the consumer takes.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_ready = (q[int'(in_sel)].size() == 0) || out_ready[in_sel];
      check("in_ready", 64'(in_ready), 64'(mon_ready));
      check("in_ready_s", 64'(in_ready_s), 64'(mon_ready));
      for (int k = 0; k < 4; k++) begin
        check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(q[k].size() != 0));
        check($sformatf("out_valid_s[%0d]", k), 64'(out_valid_s[k]), 64'(q[k].size() != 0));
        if (q[k].size() != 0) begin
          check($sformatf("out_data[%0d]", k), 64'(dat(k)), 64'(q[k][0]));
          check($sformatf("out_data_s[%0d]", k), 64'(dat_s(k)), 64'(q[k][0]));
          if (out_ready[k]) void'(q[k].pop_front());
        end
      end
      check("xfer_count", 64'(xfer_count), 64'(n_acc % 65536));
      check("xfer_count_s", 64'(xfer_count_s), 64'(n_acc % 16));
    end
  end

  // Apply one cycle of stimulus just after the rising edge, then let it settle.
  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [3:0] rdy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_xfer_count", 64'(xfer_count), 64'h0);
    check("rst_data_a", 64'(out_data_a), 64'h0);
    check("rst_data_b", 64'(out_data_b), 64'h0);
    check("rst_data_c", 64'(out_data_c), 64'h0);
    check("rst_data_d", 64'(out_data_d), 64'h0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check($sformatf("rst_in_ready_sel%0d", s), 64'(in_ready), 64'h1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] s;
    repeat (2) @(posedge clk);
    do_reset();

    // Routing with all consumers stalled.
    drive(1'b1, 2'd0, 32'h1111_1111, 4'b0000);
    drive(1'b1, 2'd1, 32'h2222_2222, 4'b0000);
    drive(1'b1, 2'd2, 32'h3333_3333, 4'b0000);
    drive(1'b1, 2'd3, 32'h4444_4444, 4'b0000);
    drive(1'b1, 2'd2, 32'h5555_5555, 4'b0000);
    check("route_in_ready", 64'(in_ready), 64'h0);
    check("route_out_valid", 64'(out_valid), 64'hf);
    check("route_count", 64'(xfer_count), 64'd4);
    check("route_a", 64'(out_data_a), 64'h1111_1111);
    check("route_b", 64'(out_data_b), 64'h2222_2222);
    check("route_c", 64'(out_data_c), 64'h3333_3333);
    check("route_d", 64'(out_data_d), 64'h4444_4444);

    // Backpressure on b, then release it for a same-edge drain and reload.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd1, 32'hBBBB_0001, 4'b0000);
      check("bp_in_ready", 64'(in_ready), 64'h0);
      check("bp_hold_b", 64'(out_data_b), 64'h2222_2222);
    end
    drive(1'b1, 2'd1, 32'hBBBB_0001, 4'b0010);
    check("bp_release_ready", 64'(in_ready), 64'h1);
    drive(1'b0, 2'd0, '0, 4'b0000);
    check("bp_valid_b", 64'(out_valid[1]), 64'h1);
    check("bp_new_b", 64'(out_data_b), 64'hBBBB_0001);
    check("bp_count", 64'(xfer_count), 64'd5);

    drive(1'b0, 2'd0, '0, 4'hf);
    drive(1'b0, 2'd0, '0, 4'hf);
    check("drain_all", 64'(out_valid), 64'h0);

    // Channel c stalled; traffic to a and d must keep flowing.
    drive(1'b1, 2'd2, 32'hCCCC_0000, 4'b1011);
    for (int i = 0; i < 20; i++) begin
      s = ($urandom % 2 != 0) ? 2'd3 : 2'd0;
      drive(1'b1, s, $urandom, 4'b1011);
      check("stall_flow_ready", 64'(in_ready), 64'h1);
      check("stall_hold_c", 64'(out_data_c), 64'hCCCC_0000);
    end

    // Random traffic and backpressure.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom), $urandom, 4'($urandom));
    end

    // Reset mid-stream with a and c holding words.
    drive(1'b0, 2'd0, '0, 4'hf);
    drive(1'b0, 2'd0, '0, 4'hf);
    drive(1'b1, 2'd0, 32'hAAAA_0000, 4'b0000);
    drive(1'b1, 2'd2, 32'hCCCC_1111, 4'b0000);
    drive(1'b0, 2'd0, '0, 4'b0000);
    check("pre_rst_valid", 64'(out_valid), 64'h5);
    do_reset();

    // Full-throughput pass-through.
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 2'($urandom), $urandom, 4'hf);
      check("pt_in_ready", 64'(in_ready), 64'h1);
    end
    drive(1'b0, 2'd0, '0, 4'hf);
    check("pt_count", 64'(xfer_count), 64'd100);

    // Counter wrap on the 4-bit instance.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 2'($urandom), $urandom, 4'hf);
      if (i == 16) check("wrap_15", 64'(xfer_count_s), 64'd15);
      if (i == 17) check("wrap_0", 64'(xfer_count_s), 64'd0);
    end
    drive(1'b0, 2'd0, '0, 4'hf);
    check("wrap_1", 64'(xfer_count_s), 64'd1);
    check("wrap_wide", 64'(xfer_count), 64'd17);

    drive(1'b0, 2'd0, '0, 4'hf);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
